// File: rtl/mouse_axis_emu.sv
// Mouse-to-analog-stick emulation for one of NUM_PORTS controller ports.
// Optional idle recentering is built when MOUSE_AXIS_AUTO_CENTER_EN is defined.
module mouse_axis_emu #(
  parameter int NUM_PORTS   = 4,
  parameter int AXIS_W      = 8,
  parameter int STEP_LIMIT  = 10,
  parameter int DELTA_SHIFT = 1,
  parameter int IDLE_TICKS  = 1 << 20,
  parameter int CENTER_DIV  = 12,
  localparam int PSW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [24:0]                   ps2_mouse,
  input  logic [PSW-1:0]                port_sel,
  input  logic                          invert_x,
  input  logic                          invert_y,
  input  logic                          halt,
  input  logic [NUM_PORTS*2*AXIS_W-1:0] joya_in,
  input  logic [NUM_PORTS*2-1:0]        btn_in,
  output logic [NUM_PORTS*2*AXIS_W-1:0] joya_out,
  output logic [NUM_PORTS*2-1:0]        btn_out,
  output logic                          emu_active
);

  // state     | meaning
  // ST_PASS   | every port passes hps_io analog/buttons straight through
  // ST_MOUSE  | mouse accumulators own the axes of port_sel

  typedef enum logic {ST_PASS, ST_MOUSE} state_t;

  localparam int SW = AXIS_W + 2;
  localparam logic signed [9:0]    LIM_P   = 10'(STEP_LIMIT);
  localparam logic signed [9:0]    LIM_N   = -LIM_P;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (AXIS_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_old_stb;
  logic [PSW-1:0]           r_port_sel_q;
  logic signed [AXIS_W-1:0] r_acc_x;
  logic signed [AXIS_W-1:0] r_acc_y;
  logic signed [AXIS_W-1:0] w_acc_x_nxt;
  logic signed [AXIS_W-1:0] w_acc_y_nxt;
  logic signed [9:0]        w_dx;
  logic signed [9:0]        w_dy;
  logic [2*AXIS_W-1:0]      w_sel_axes;
  logic                     w_pkt;
  logic                     w_release;
  logic                     w_own;
  logic                     w_center_step;
  logic [NUM_PORTS*2*AXIS_W-1:0] w_joya_mux;
  logic [NUM_PORTS*2-1:0]        w_btn_mux;
  logic                     w_unused_bits;

  assign w_unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  // Recentering parameters are only consumed by the optional counters.
  if (IDLE_TICKS < 1 || CENTER_DIV < 1) begin : g_cfg_guard
  end

  function automatic logic signed [9:0] clamp_delta(input logic sgn, input logic [7:0] mag);
    logic signed [9:0] raw;
    logic signed [9:0] sh;
    raw = {sgn, sgn, mag};
    sh  = raw >>> DELTA_SHIFT;
    if (sh > LIM_P)      return LIM_P;
    else if (sh < LIM_N) return LIM_N;
    else                 return sh;
  endfunction

  // Widened by two bits so the sum can be saturated instead of wrapping.
  function automatic logic signed [AXIS_W-1:0] acc_step(input logic signed [AXIS_W-1:0] acc,
                                                       input logic signed [9:0] d,
                                                       input logic inv);
    logic signed [SW-1:0] a;
    logic signed [SW-1:0] e;
    logic signed [SW-1:0] n;
    a = SW'(acc);
    e = SW'(d);
    n = inv ? (a - e) : (a + e);
    if (n > SAT_MAX)      return AXIS_W'(SAT_MAX);
    else if (n < SAT_MIN) return AXIS_W'(SAT_MIN);
    else                  return AXIS_W'(n);
  endfunction

  function automatic logic signed [AXIS_W-1:0] toward_zero(input logic signed [AXIS_W-1:0] a);
    if (a > 0)      return a - AXIS_W'(1);
    else if (a < 0) return a + AXIS_W'(1);
    else            return a;
  endfunction

  assign w_dx  = clamp_delta(ps2_mouse[4], ps2_mouse[15:8]);
  assign w_dy  = clamp_delta(ps2_mouse[5], ps2_mouse[23:16]);
  assign w_pkt = ps2_mouse[24] ^ r_old_stb;

  always_comb begin
    w_sel_axes = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PSW'(p) == port_sel) w_sel_axes = joya_in[p*2*AXIS_W +: 2*AXIS_W];
    end
  end

  // Real stick activity, a halted core or a port switch hands the port back.
  assign w_release  = (w_sel_axes != '0) | halt | (port_sel != r_port_sel_q);
  assign w_own      = (r_state == ST_MOUSE) & ~w_release;
  assign emu_active = (r_state == ST_MOUSE);

`ifdef MOUSE_AXIS_AUTO_CENTER_EN
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0] IDLE_TC = IW'(IDLE_TICKS);

  logic [IW-1:0]         r_idle_cnt;
  logic [CENTER_DIV-1:0] r_div_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_idle_cnt <= '0;
      r_div_cnt  <= '0;
    end else if (r_state != ST_MOUSE || w_pkt || w_release) begin
      r_idle_cnt <= '0;
      r_div_cnt  <= '0;
    end else if (r_idle_cnt != IDLE_TC) begin
      r_idle_cnt <= r_idle_cnt + IW'(1);
      r_div_cnt  <= '0;
    end else begin
      r_div_cnt  <= r_div_cnt + CENTER_DIV'(1);
    end
  end

  assign w_center_step = (r_state == ST_MOUSE) && (r_idle_cnt == IDLE_TC) && (&r_div_cnt);
`else
  assign w_center_step = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_acc_x_nxt = r_acc_x;
    w_acc_y_nxt = r_acc_y;
    if (w_release) begin
      w_state_nxt = ST_PASS;
      w_acc_x_nxt = '0;
      w_acc_y_nxt = '0;
    end else if (w_pkt) begin
      w_state_nxt = ST_MOUSE;
      w_acc_x_nxt = acc_step(r_acc_x, w_dx, invert_x);
      w_acc_y_nxt = acc_step(r_acc_y, w_dy, invert_y);
    end else if (w_center_step) begin
      w_acc_x_nxt = toward_zero(r_acc_x);
      w_acc_y_nxt = toward_zero(r_acc_y);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_PASS;
      r_acc_x <= '0;
      r_acc_y <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc_x <= w_acc_x_nxt;
      r_acc_y <= w_acc_y_nxt;
    end
  end

  // Strobe history tracks the input through reset so no packet is seen on exit.
  always_ff @(posedge clk_sys) begin
    r_old_stb    <= ps2_mouse[24];
    r_port_sel_q <= port_sel;
  end

  always_comb begin
    w_joya_mux = joya_in;
    w_btn_mux  = btn_in;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_own && (PSW'(p) == port_sel)) begin
        w_joya_mux[p*2*AXIS_W +: 2*AXIS_W] = {r_acc_y, r_acc_x};
        w_btn_mux[p*2 +: 2]                = ps2_mouse[1:0] | btn_in[p*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      joya_out <= '0;
      btn_out  <= '0;
    end else begin
      joya_out <= w_joya_mux;
      btn_out  <= w_btn_mux;
    end
  end

endmodule

// File: tb/tb_mouse_axis_emu.sv
// Bench for mouse_axis_emu: spec-level model checked every cycle plus literal pins.
// Recentering checks are compiled in when MOUSE_AXIS_AUTO_CENTER_EN is defined.
module tb_mouse_axis_emu;
  localparam int TB_IDLE   = 16;
  localparam int TB_DIV    = 2;
  localparam int TB_PERIOD = 1 << TB_DIV;
  localparam logic [63:0] JIN = 64'h8001_00FF_1234_0000;
  localparam logic [7:0]  BIN = 8'h9E;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic [1:0]  port_sel;
  logic        invert_x, invert_y, halt;
  logic [63:0] joya_in;
  logic [7:0]  btn_in;
  logic [63:0] joya_out;
  logic [7:0]  btn_out;
  logic        emu_active;

  int n_tests = 0;
  int n_fail  = 0;

  mouse_axis_emu #(
    .NUM_PORTS(4), .AXIS_W(8), .STEP_LIMIT(10), .DELTA_SHIFT(1),
    .IDLE_TICKS(TB_IDLE), .CENTER_DIV(TB_DIV)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .port_sel(port_sel),
    .invert_x(invert_x), .invert_y(invert_y), .halt(halt), .joya_in(joya_in),
    .btn_in(btn_in), .joya_out(joya_out), .btn_out(btn_out), .emu_active(emu_active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stick position as plain integers.
  function automatic int dval(input bit s, input logic [7:0] m);
    int v;
    v = s ? int'(m) - 256 : int'(m);
    v = v >>> 1;
    if (v > 10)  v = 10;
    if (v < -10) v = -10;
    return v;
  endfunction

  function automatic int sat(input int n);
    if (n > 127)  return 127;
    if (n < -128) return -128;
    return n;
  endfunction

  function automatic int tz(input int a);
    if (a > 0) return a - 1;
    if (a < 0) return a + 1;
    return a;
  endfunction

  int          m_ax = 0, m_ay = 0, m_idle = 0;
  bit          m_act = 0, m_old = 0, m_valid = 0;
  logic [1:0]  m_psel = '0;
  logic [63:0] exp_joya = '0;
  logic [7:0]  exp_btn = '0;

  always @(posedge clk_sys) begin
    bit rel, own, pkt;
    int dx, dy;
    if (reset) begin
      exp_joya = '0; exp_btn = '0;
      m_act = 0; m_ax = 0; m_ay = 0; m_idle = 0;
    end else begin
      rel = (joya_in[port_sel*16 +: 16] != 16'h0) || halt || (port_sel != m_psel);
      own = m_act && !rel;
      exp_joya = joya_in;
      exp_btn  = btn_in;
      if (own) begin
        exp_joya[port_sel*16 +: 16] = {m_ay[7:0], m_ax[7:0]};
        exp_btn[port_sel*2 +: 2]    = ps2_mouse[1:0] | btn_in[port_sel*2 +: 2];
      end
      pkt = (ps2_mouse[24] != m_old);
      dx = dval(ps2_mouse[4], ps2_mouse[15:8]);
      dy = dval(ps2_mouse[5], ps2_mouse[23:16]);
      if (rel) begin
        m_act = 0; m_ax = 0; m_ay = 0; m_idle = 0;
      end else if (pkt) begin
        m_act = 1; m_idle = 0;
        m_ax = sat(invert_x ? m_ax - dx : m_ax + dx);
        m_ay = sat(invert_y ? m_ay - dy : m_ay + dy);
      end else if (m_act) begin
        m_idle++;
`ifdef MOUSE_AXIS_AUTO_CENTER_EN
        if (m_idle > TB_IDLE && ((m_idle - TB_IDLE) % TB_PERIOD) == 0) begin
          m_ax = tz(m_ax);
          m_ay = tz(m_ay);
        end
`endif
      end else begin
        m_idle = 0;
      end
    end
    m_old   = ps2_mouse[24];
    m_psel  = port_sel;
    m_valid = 1;
  end

  always @(posedge clk_sys) begin
    #1;
    if (m_valid) begin
      chk("model_joya_out", joya_out, exp_joya);
      chk("model_btn_out", {56'h0, btn_out}, {56'h0, exp_btn});
      chk("model_emu_active", {63'h0, emu_active}, {63'h0, m_act});
    end
  end

  task automatic pkt(input bit sx, input logic [7:0] x, input bit sy, input logic [7:0] y,
                     input logic [1:0] b);
    ps2_mouse = {~ps2_mouse[24], y, x, 2'b00, sy, sx, 2'b00, b};
    @(negedge clk_sys);
  endtask

  initial begin
    reset = 1'b1; ps2_mouse = 25'h1000000; port_sel = 2'd0;
    invert_x = 1'b0; invert_y = 1'b0; halt = 1'b0;
    joya_in = JIN; btn_in = BIN;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("t1_inactive", {63'h0, emu_active}, 64'h0);
    chk("t1_pass_axes", joya_out, JIN);
    chk("t1_pass_btn", {56'h0, btn_out}, {56'h0, BIN});

    pkt(1'b0, 8'h08, 1'b0, 8'h00, 2'b01);
    chk("t2_active", {63'h0, emu_active}, 64'h1);
    @(negedge clk_sys);
    chk("t2_acc_x4", joya_out, 64'h8001_00FF_1234_0004);
    chk("t2_btn_or", {56'h0, btn_out}, 64'h9F);
    pkt(1'b0, 8'h08, 1'b1, 8'hF0, 2'b00);
    @(negedge clk_sys);
    chk("t2_xy", {48'h0, joya_out[15:0]}, 64'hF808);

    for (int i = 0; i < 20; i++) pkt(1'b0, 8'd60, 1'b0, 8'h00, 2'b00);
    @(negedge clk_sys);
    chk("t3_sat_pos", {48'h0, joya_out[15:0]}, 64'hF87F);
    invert_x = 1'b1;
    for (int i = 0; i < 26; i++) pkt(1'b0, 8'd60, 1'b0, 8'h00, 2'b00);
    @(negedge clk_sys);
    chk("t3_sat_neg", {48'h0, joya_out[15:0]}, 64'hF880);
    invert_x = 1'b0; invert_y = 1'b1;
    pkt(1'b0, 8'h00, 1'b0, 8'h02, 2'b00);
    @(negedge clk_sys);
    chk("t3_inv_y", {48'h0, joya_out[15:0]}, 64'hF780);
    invert_y = 1'b0;

    joya_in[15:0] = 16'h0100;
    pkt(1'b0, 8'h08, 1'b0, 8'h00, 2'b00);
    chk("t4_release_wins", {63'h0, emu_active}, 64'h0);
    chk("t4_pass", {48'h0, joya_out[15:0]}, 64'h0100);
    joya_in = JIN;
    @(negedge clk_sys);
    pkt(1'b0, 8'h08, 1'b0, 8'h00, 2'b00);
    @(negedge clk_sys);
    chk("t4_acc_cleared", {48'h0, joya_out[15:0]}, 64'h0004);

    port_sel = 2'd1;
    @(negedge clk_sys);
    chk("t5_portsel_release", {63'h0, emu_active}, 64'h0);
    chk("t5_restored", joya_out, JIN);
    port_sel = 2'd0;
    @(negedge clk_sys);
    pkt(1'b0, 8'h08, 1'b0, 8'h00, 2'b00);
    @(negedge clk_sys);
    chk("t5_acc_cleared", {48'h0, joya_out[15:0]}, 64'h0004);

    halt = 1'b1;
    @(negedge clk_sys);
    chk("halt_release", {63'h0, emu_active}, 64'h0);
    halt = 1'b0;
    @(negedge clk_sys);

    pkt(1'b1, 8'h00, 1'b0, 8'h00, 2'b00);
    @(negedge clk_sys);
    chk("clamp_neg", {56'h0, joya_out[7:0]}, 64'hF6);
    pkt(1'b0, 8'h17, 1'b0, 8'h00, 2'b00);
    @(negedge clk_sys);
    chk("clamp_pos_edge", {56'h0, joya_out[7:0]}, 64'h00);
    pkt(1'b0, 8'h13, 1'b0, 8'h00, 2'b00);
    @(negedge clk_sys);
    chk("below_limit", {56'h0, joya_out[7:0]}, 64'h09);

    ps2_mouse[24] = ~ps2_mouse[24];
    reset = 1'b1;
    @(negedge clk_sys);
    chk("midreset_inactive", {63'h0, emu_active}, 64'h0);
    chk("midreset_out", joya_out, 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("midreset_no_pkt", joya_out, JIN);

    pkt(1'b0, 8'h06, 1'b0, 8'h00, 2'b00);
`ifdef MOUSE_AXIS_AUTO_CENTER_EN
    repeat (21) @(negedge clk_sys);
    chk("t6_mid_center", {56'h0, joya_out[7:0]}, 64'h02);
    repeat (8) @(negedge clk_sys);
    chk("t6_centered", {56'h0, joya_out[7:0]}, 64'h00);
    chk("t6_still_active", {63'h0, emu_active}, 64'h1);
`else
    repeat (40) @(negedge clk_sys);
    chk("t6_hold", {56'h0, joya_out[7:0]}, 64'h03);
    chk("t6_still_active", {63'h0, emu_active}, 64'h1);
`endif
    repeat (2) @(negedge clk_sys);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
